// File: rtl/lut_cfg_n.sv
// lut_cfg_n: run-time reconfigurable K-input lookup table with NOUT output
// channels sharing one select bus. The table is shifted in serially into a
// shadow copy and committed atomically, so lookups only ever see a complete
// table. The previous table streams out on cfg_dout during a load.
module lut_cfg_n #(
  parameter int                        K       = 5,
  parameter int                        NOUT    = 1,
  parameter logic [NOUT*(2**K)-1:0]    INIT    = '0,
  parameter int                        REG_OUT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_start,
  input  logic            cfg_abort,
  input  logic            cfg_valid,
  input  logic            cfg_din,
  output logic            cfg_dout,
  output logic            cfg_busy,
  output logic            cfg_done,
  input  logic            in_valid,
  input  logic [K-1:0]    in_sel,
  output logic            out_valid,
  output logic [NOUT-1:0] out
);

  localparam int DEPTH = 2**K;
  localparam int W     = NOUT * DEPTH;
  localparam int CNT_W = $clog2(W) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [W-1:0]       active;
  logic [W-1:0]       shadow;
  logic [CNT_W-1:0]   bit_cnt;
  logic               load_en;
  logic               shift_en;
  logic               commit_en;

  // Per-channel table read: channel j owns bits [j*DEPTH +: DEPTH].
  function automatic logic [NOUT-1:0] lookup(input logic [W-1:0] tab,
                                             input logic [K-1:0] sel);
    logic [NOUT-1:0]  res;
    logic [DEPTH-1:0] chan;
    res = '0;
    for (int j = 0; j < NOUT; j++) begin
      chan   = tab[j*DEPTH +: DEPTH];
      res[j] = chan[sel];
    end
    return res;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode; abort wins over a shift in the same cycle.
  always_comb begin
    state_nxt = state;
    cfg_busy  = 1'b0;
    cfg_done  = 1'b0;
    load_en   = 1'b0;
    shift_en  = 1'b0;
    commit_en = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          load_en   = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        cfg_busy = 1'b1;
        if (cfg_abort) begin
          state_nxt = IDLE;
        end else if (cfg_valid) begin
          shift_en = 1'b1;
          if (bit_cnt == CNT_W'(W - 1)) begin
            state_nxt = COMMIT;
          end
        end
      end
      COMMIT: begin
        cfg_done  = 1'b1;
        commit_en = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Shadow shift register and bit counter; a new load starts from a copy of
  // the active table so the old contents stream out MSB first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= INIT;
      bit_cnt <= '0;
    end else if (load_en) begin
      shadow  <= active;
      bit_cnt <= '0;
    end else if (shift_en) begin
      shadow  <= {shadow[W-2:0], cfg_din};
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Active table: replaced as a whole on commit only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= INIT;
    end else if (commit_en) begin
      active <= shadow;
    end
  end

  assign cfg_dout = shadow[W-1];

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [NOUT-1:0] out_p1;
      logic            vld_p1;

      // ---- stage p0 -> p1: registered lookup; result holds when idle ----
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_p1 <= '0;
          vld_p1 <= 1'b0;
        end else begin
          vld_p1 <= in_valid;
          if (in_valid) begin
            out_p1 <= lookup(active, in_sel);
          end
        end
      end

      assign out       = out_p1;
      assign out_valid = vld_p1;
    end else begin : g_comb_out
      assign out       = lookup(active, in_sel);
      assign out_valid = in_valid;
    end
  endgenerate

endmodule

// File: tb/tb_lut_cfg_n.sv
// Bench for lut_cfg_n: a K=5 single-channel instance and a K=2 two-channel
// instance. Lookup expectations go into per-instance queues and are checked
// by monitors whenever out_valid is seen; configuration handshakes are
// checked inline.
module tb_lut_cfg_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 1: K=5, NOUT=1, INIT=0, REG_OUT=1
  logic       rst, cfg_start, cfg_abort, cfg_valid, cfg_din;
  logic       cfg_dout, cfg_busy, cfg_done;
  logic       in_valid, out_valid;
  logic [4:0] in_sel;
  logic [0:0] out;

  // Instance 2: K=2, NOUT=2, INIT=8'h96, REG_OUT=1
  logic       rst2, cfg2_start, cfg2_abort, cfg2_valid, cfg2_din;
  logic       cfg2_dout, cfg2_busy, cfg2_done;
  logic       in2_valid, out2_valid;
  logic [1:0] in2_sel;
  logic [1:0] out2;

  lut_cfg_n #(.K(5), .NOUT(1), .INIT(32'h0), .REG_OUT(1)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_valid(cfg_valid), .cfg_din(cfg_din), .cfg_dout(cfg_dout),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .in_valid(in_valid),
    .in_sel(in_sel), .out_valid(out_valid), .out(out)
  );

  lut_cfg_n #(.K(2), .NOUT(2), .INIT(8'h96), .REG_OUT(1)) dut2 (
    .clk(clk), .rst(rst2), .cfg_start(cfg2_start), .cfg_abort(cfg2_abort),
    .cfg_valid(cfg2_valid), .cfg_din(cfg2_din), .cfg_dout(cfg2_dout),
    .cfg_busy(cfg2_busy), .cfg_done(cfg2_done), .in_valid(in2_valid),
    .in_sel(in2_sel), .out_valid(out2_valid), .out(out2)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [0:0] q1[$];
  logic [1:0] q2[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: compare every presented result against the next expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (q1.size() == 0) begin
        n_chk++;
        $display("FAIL lut1_extra: got out=%0b with no pending lookup, required none", out);
      end else begin
        chk("lut1_out", 32'(out), 32'(q1.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (out2_valid === 1'b1) begin
      if (q2.size() == 0) begin
        n_chk++;
        $display("FAIL lut2_extra: got out=%0b with no pending lookup, required none", out2);
      end else begin
        chk("lut2_out", 32'(out2), 32'(q2.pop_front()));
      end
    end
  end

  task automatic lookup1(input logic [4:0] sel, input logic exp);
    in_valid = 1'b1;
    in_sel   = sel;
    q1.push_back(exp);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic lookup2(input logic [1:0] sel, input logic [1:0] exp);
    in2_valid = 1'b1;
    in2_sel   = sel;
    q2.push_back(exp);
    tick();
    in2_valid = 1'b0;
  endtask

  // Full 32-bit load on instance 1; every gap-th cycle has cfg_valid low.
  task automatic load1(input logic [31:0] data, input int gap,
                       output logic [31:0] dout_seq, output logic busy_ok,
                       output int done_cnt);
    int cyc;
    cyc      = 0;
    busy_ok  = 1'b1;
    done_cnt = 0;
    dout_seq = '0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      while (gap > 0 && (cyc % gap) == gap - 1) begin
        cfg_valid = 1'b0;
        if (cfg_busy !== 1'b1) busy_ok = 1'b0;
        if (cfg_done === 1'b1) done_cnt++;
        tick();
        cyc++;
      end
      dout_seq[31-i] = cfg_dout;
      if (cfg_busy !== 1'b1) busy_ok = 1'b0;
      if (cfg_done === 1'b1) done_cnt++;
      cfg_valid = 1'b1;
      cfg_din   = data[31-i];
      tick();
      cyc++;
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] seq;
    logic        bok;
    int          dcnt;
    logic [7:0]  seq2;
    logic [7:0]  pat2;

    rst = 1'b1; cfg_start = 0; cfg_abort = 0; cfg_valid = 0; cfg_din = 0;
    in_valid = 0; in_sel = '0;
    rst2 = 1'b1; cfg2_start = 0; cfg2_abort = 0; cfg2_valid = 0; cfg2_din = 0;
    in2_valid = 0; in2_sel = '0;
    pat2 = 8'h3C;

    // Reset state, lookups held off while reset is asserted
    repeat (2) tick();
    chk("rst_busy", 32'(cfg_busy), 0);
    chk("rst_done", 32'(cfg_done), 0);
    chk("rst_dout", 32'(cfg_dout), 0);
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1;
      in_sel   = 5'(i);
      tick();
      chk("rst_out_vld", {30'b0, out_valid, out}, 0);
    end
    in_valid = 1'b0;
    rst  = 1'b0;
    rst2 = 1'b0;
    tick();
    lookup1(5'd0, 1'b0);
    lookup1(5'd7, 1'b0);
    lookup1(5'd31, 1'b0);

    // Gapped load of A5A5_0F0F
    load1(32'hA5A5_0F0F, 3, seq, bok, dcnt);
    chk("load1_done_pulse", 32'(cfg_done), 1);
    chk("load1_busy_commit", 32'(cfg_busy), 0);
    chk("load1_busy_during", 32'(bok), 1);
    chk("load1_no_early_done", 32'(dcnt), 0);
    chk("load1_readback_init", seq, 32'h0);
    tick();
    chk("load1_done_one_cycle", 32'(cfg_done), 0);
    lookup1(5'd0, 1'b1);
    lookup1(5'd4, 1'b0);
    lookup1(5'd16, 1'b1);
    lookup1(5'd17, 1'b0);
    lookup1(5'd31, 1'b1);

    // Readback of the previous table while loading zeros
    load1(32'h0, 0, seq, bok, dcnt);
    chk("readback_seq", seq, 32'hA5A5_0F0F);
    chk("load2_done_pulse", 32'(cfg_done), 1);
    tick();
    for (int i = 0; i < 32; i++) lookup1(5'(i), 1'b0);

    // Abort after 10 valid bits of all-ones
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cfg_valid = 1'b1;
      cfg_din   = 1'b1;
      tick();
    end
    chk("abort_busy_before", 32'(cfg_busy), 1);
    cfg_abort = 1'b1;
    cfg_valid = 1'b1;
    tick();
    chk("abort_busy_drop", 32'(cfg_busy), 0);
    chk("abort_no_done", 32'(cfg_done), 0);
    cfg_abort = 1'b0;
    cfg_valid = 1'b0;
    tick();
    chk("abort_no_done_later", 32'(cfg_done), 0);
    lookup1(5'd0, 1'b0);
    lookup1(5'd5, 1'b0);
    lookup1(5'd9, 1'b0);
    lookup1(5'd31, 1'b0);

    // Commit boundary: in_sel=0 held valid across the commit of 32'h1
    in_valid = 1'b1;
    in_sel   = 5'd0;
    cfg_start = 1'b1;
    q1.push_back(1'b0);
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      cfg_valid = 1'b1;
      cfg_din   = (i == 31);
      q1.push_back(1'b0);
      tick();
    end
    cfg_valid = 1'b0;
    chk("boundary_in_commit", 32'(cfg_done), 1);
    q1.push_back(1'b0);
    tick();
    q1.push_back(1'b1);
    tick();
    q1.push_back(1'b1);
    tick();
    in_valid = 1'b0;

    // Instance 2: reset in the middle of loading 8'h3C
    cfg2_start = 1'b1;
    tick();
    cfg2_start = 1'b0;
    chk("m_busy_load", 32'(cfg2_busy), 1);
    for (int i = 0; i < 5; i++) begin
      cfg2_valid = 1'b1;
      cfg2_din   = pat2[7-i];
      tick();
    end
    cfg2_valid = 1'b0;
    #2 rst2 = 1'b1;
    #1;
    chk("m_rst_busy", 32'(cfg2_busy), 0);
    chk("m_rst_done", 32'(cfg2_done), 0);
    chk("m_rst_dout", 32'(cfg2_dout), 1);
    tick();
    rst2 = 1'b0;
    tick();
    // IDLE ignores cfg_valid without a start
    for (int i = 0; i < 3; i++) begin
      cfg2_valid = 1'b1;
      cfg2_din   = 1'b0;
      tick();
    end
    cfg2_valid = 1'b0;
    chk("m_idle_busy", 32'(cfg2_busy), 0);
    lookup2(2'd0, 2'b10);
    lookup2(2'd1, 2'b01);
    lookup2(2'd2, 2'b01);
    lookup2(2'd3, 2'b10);

    // Instance 2: full load of 8'h3C, readback must be INIT
    cfg2_start = 1'b1;
    tick();
    cfg2_start = 1'b0;
    seq2 = '0;
    for (int i = 0; i < 8; i++) begin
      seq2[7-i]  = cfg2_dout;
      cfg2_valid = 1'b1;
      cfg2_din   = pat2[7-i];
      tick();
    end
    cfg2_valid = 1'b0;
    chk("m_readback", 32'(seq2), 32'h96);
    chk("m_done_pulse", 32'(cfg2_done), 1);
    tick();
    lookup2(2'd0, 2'b10);
    lookup2(2'd1, 2'b10);
    lookup2(2'd2, 2'b01);
    lookup2(2'd3, 2'b01);

    repeat (3) tick();
    chk("lut1_drained", 32'(q1.size()), 0);
    chk("lut2_drained", 32'(q2.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
